// File: rtl/multiple_bits_serial_subtractor.sv
// Bit-serial subtractor: Difference = Minuend - Subtrahend - Borrow_in, LSB first, one bit per clock.
// Define SUB_OVERFLOW_EN to add the registered two's-complement Overflow output.
module multiple_bits_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Minuend,
  input  logic [WIDTH-1:0] Subtrahend,
  input  logic             Borrow_in,
  output logic [WIDTH-1:0] Difference,
  output logic             Borrow_out,
`ifdef SUB_OVERFLOW_EN
  output logic             Overflow,
`endif
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             load;
  logic             shift;
  logic             last;
  logic             d_bit;
  logic             br_next;

  // One-bit full subtractor: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

  assign {br_next, d_bit} = full_sub(a_sr[0], b_sr[0], br);
  assign last             = (cnt == CNT_LAST);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE accepts a new Start directly, giving back-to-back throughput.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state == SHIFT);
  assign Done = (state == DONE);

  // Result bits enter from the MSB side; outputs are written only on the final bit.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      Difference <= '0;
      Borrow_out <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      Overflow   <= 1'b0;
`endif
    end else if (load) begin
      a_sr <= Minuend;
      b_sr <= Subtrahend;
      br   <= Borrow_in;
      cnt  <= '0;
    end else if (shift) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= (WIDTH-1)'({d_bit, res_sr} >> 1);
      br     <= br_next;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        Difference <= {d_bit, res_sr};
        Borrow_out <= br_next;
`ifdef SUB_OVERFLOW_EN
        // On the last bit a_sr[0]/b_sr[0] are the operand sign bits.
        Overflow   <= (a_sr[0] ^ b_sr[0]) & (d_bit ^ a_sr[0]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_multiple_bits_serial_subtractor.sv
// Testbench for multiple_bits_serial_subtractor (WIDTH=4): directed table, corner sequences,
// exhaustive sweep and randomized operations against an arithmetic reference model.
module tb_multiple_bits_serial_subtractor;

  localparam int W = 4;

  logic         Clk;
  logic         Rst;
  logic         Start;
  logic [W-1:0] Minuend;
  logic [W-1:0] Subtrahend;
  logic         Borrow_in;
  logic [W-1:0] Difference;
  logic         Borrow_out;
`ifdef SUB_OVERFLOW_EN
  logic         Overflow;
`endif
  logic         Busy;
  logic         Done;

  int checks = 0;
  int errors = 0;

  multiple_bits_serial_subtractor #(.WIDTH(W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Minuend    (Minuend),
    .Subtrahend (Subtrahend),
    .Borrow_in  (Borrow_in),
    .Difference (Difference),
    .Borrow_out (Borrow_out),
`ifdef SUB_OVERFLOW_EN
    .Overflow   (Overflow),
`endif
    .Busy       (Busy),
    .Done       (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: {Borrow_out, Difference} is the difference modulo 2^(W+1).
  function automatic int ref_full(input int a, input int b, input int bin);
    int r;
    r = a - b - bin;
    return r & ((1 << (W + 1)) - 1);
  endfunction

  // Reference: signed result falls outside the W-bit two's-complement range.
  function automatic int ref_ov(input int a, input int b, input int bin);
    int sa;
    int sb;
    int s;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    s  = sa - sb - bin;
    return ((s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1)) ? 1 : 0;
  endfunction

  // Called right after a negedge; returns at the negedge where Done is seen (or on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input int spur, output logic [W-1:0] d, output logic bo,
                        output logic ov, output int lat, output int busy_n);
    Minuend    = a;
    Subtrahend = b;
    Borrow_in  = bin;
    Start      = 1'b1;
    @(negedge Clk);
    Minuend    = W'($urandom());
    Subtrahend = W'($urandom());
    Borrow_in  = 1'($urandom());
    Start      = (spur == 0);
    lat        = 0;
    busy_n     = 0;
    while (!Done && lat < 20) begin
      if (Busy) busy_n++;
      @(negedge Clk);
      lat++;
      Start = (lat == spur);
    end
    Start = 1'b0;
    d     = Difference;
    bo    = Borrow_out;
`ifdef SUB_OVERFLOW_EN
    ov    = Overflow;
`else
    ov    = 1'b0;
`endif
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input int spur, input int exp_full, input int exp_ov);
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           lat;
    int           busy_n;
    run_op(a, b, bin, spur, d, bo, ov, lat, busy_n);
    check({name, " result"}, int'({bo, d}), exp_full);
    check({name, " latency"}, lat, W);
    check({name, " busy cycles"}, busy_n, W);
`ifdef SUB_OVERFLOW_EN
    check({name, " overflow"}, int'(ov), exp_ov);
`else
    if (ov !== 1'b0) check({name, " overflow"}, int'(ov), 0);
    if (exp_ov < 0) check({name, " ov model"}, exp_ov, 0);
`endif
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!Done && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!Done) check({name, " timeout"}, 0, 1);
  endtask

  initial begin
    int n;
    int gap;
    int done_n;
    logic [W-1:0] held;

    tbl[0] = '{"10-3",    4'd10, 4'd3,  1'b0, 4'b0111, 1'b0, 1'b1};
    tbl[1] = '{"3-10",    4'd3,  4'd10, 1'b0, 4'b1001, 1'b1, 1'b1};
    tbl[2] = '{"0-0-1",   4'd0,  4'd0,  1'b1, 4'b1111, 1'b1, 1'b0};
    tbl[3] = '{"5-3",     4'd5,  4'd3,  1'b0, 4'b0010, 1'b0, 1'b0};
    tbl[4] = '{"8-1",     4'd8,  4'd1,  1'b0, 4'b0111, 1'b0, 1'b1};
    tbl[5] = '{"15-9",    4'd15, 4'd9,  1'b0, 4'b0110, 1'b0, 1'b0};
    tbl[6] = '{"7-7-1",   4'd7,  4'd7,  1'b1, 4'b1111, 1'b1, 1'b0};
    tbl[7] = '{"0-15",    4'd0,  4'd15, 1'b0, 4'b0001, 1'b1, 1'b0};

    Rst        = 1'b1;
    Start      = 1'b0;
    Minuend    = '0;
    Subtrahend = '0;
    Borrow_in  = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset Difference", int'(Difference), 0);
    check("reset Borrow_out", int'(Borrow_out), 0);
    check("reset Busy", int'(Busy), 0);
    check("reset Done", int'(Done), 0);
`ifdef SUB_OVERFLOW_EN
    check("reset Overflow", int'(Overflow), 0);
`endif
    Rst = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].bin, -1,
            int'({tbl[i].bo, tbl[i].d}), int'(tbl[i].ov));
      repeat (2) @(negedge Clk);
    end

    // Start while busy is ignored: one Done, first operands win.
    Minuend = 4'd12; Subtrahend = 4'd4; Borrow_in = 1'b0; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk); Minuend = 4'd1; Subtrahend = 4'd1; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    done_n = 0;
    held   = '0;
    for (int k = 0; k < 12; k++) begin
      if (Done) begin
        done_n++;
        held = Difference;
      end
      @(negedge Clk);
    end
    check("busy-start done count", done_n, 1);
    check("busy-start result", int'(held), 8);
    check("busy-start held", int'(Difference), 8);

    // Back-to-back: second request presented on the Done cycle.
    Minuend = 4'd15; Subtrahend = 4'd9; Borrow_in = 1'b0; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    wait_done("b2b first", n);
    check("b2b first result", int'({Borrow_out, Difference}), 6);
    Minuend = 4'd7; Subtrahend = 4'd7; Borrow_in = 1'b1; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    Minuend = 4'd3; Subtrahend = 4'd0;
    wait_done("b2b second", n);
    check("b2b done spacing", n + 1, 5);
    check("b2b second result", int'({Borrow_out, Difference}), 31);

    // Asynchronous reset mid-operation.
    @(negedge Clk);
    Minuend = 4'd14; Subtrahend = 4'd10; Borrow_in = 1'b0; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("async rst Difference", int'(Difference), 0);
    check("async rst Borrow_out", int'(Borrow_out), 0);
    check("async rst Busy", int'(Busy), 0);
    check("async rst Done", int'(Done), 0);
    @(negedge Clk); Rst = 1'b0;
    done_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (Done) done_n++;
    end
    check("no done after rst", done_n, 0);
    do_op("post-rst 5-3", 4'd5, 4'd3, 1'b0, -1, 2, 0);
    @(negedge Clk);

    // Exhaustive sweep, issued back to back.
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        for (int c = 0; c < 2; c++) begin
          do_op($sformatf("sweep %0d-%0d-%0d", a, b, c), W'(a), W'(b), 1'(c), -1,
                ref_full(a, b, c), ref_ov(a, b, c));
        end
      end
    end

    // Randomized operations with spurious Starts while busy and random idle gaps.
    for (int i = 0; i < 150; i++) begin
      int ra;
      int rb;
      int rc;
      int spur;
      ra   = int'($urandom_range(0, (1 << W) - 1));
      rb   = int'($urandom_range(0, (1 << W) - 1));
      rc   = int'($urandom_range(0, 1));
      spur = int'($urandom_range(0, W)) - 1;
      do_op($sformatf("rand %0d: %0d-%0d-%0d", i, ra, rb, rc), W'(ra), W'(rb), 1'(rc), spur,
            ref_full(ra, rb, rc), ref_ov(ra, rb, rc));
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge Clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
